sram_port_arbiter: RTL and testbench

//  Shares one synchronous single-port SRAM (1-cycle read latency) between the IF-stage fetch

---
 rtl/sram_port_arbiter.sv | 150 +++++++++++++++
 tb/tb_sram_port_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one single-port synchronous SRAM (1-cycle read latency)
// between the fetch requester (read-only) and the load/store requester.
// Data wins contested cycles unless fetch has lost STARVE_LIMIT of them in a row.
// Optional build macro: ARB_PERF_CNT_EN adds grant/conflict performance counters.
module sram_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned STARVE_W     = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic [3:0]  data_we,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        sram_en,
  output logic [3:0]  sram_we,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
`ifdef ARB_PERF_CNT_EN
  output logic [31:0] perf_inst_grants,
  output logic [31:0] perf_data_grants,
  output logic [31:0] perf_conflicts,
`endif
  input  logic [31:0] sram_rdata
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    INST_RESP = 2'd1,
    DATA_RESP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
  logic                starve_hit;
  logic                grant_data;
  logic                grant_inst;

  // Arbitration: data has priority unless fetch is starved; nothing is granted during reset.
  always_comb begin
    starve_hit = inst_req && (starve_cnt_q == STARVE_W'(STARVE_LIMIT));
    grant_data = !reset && data_req && !starve_hit;
    grant_inst = !reset && inst_req && !grant_data;
  end

  // Request-side outputs, next state and starvation counter update.
  always_comb begin
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    sram_en      = 1'b0;
    sram_we      = 4'b0000;
    sram_addr    = 32'h0;
    sram_wdata   = 32'h0;
    state_d      = IDLE;
    starve_cnt_d = starve_cnt_q;

    if (grant_data) begin
      data_addr_ok = 1'b1;
      sram_en      = 1'b1;
      sram_we      = data_we;
      sram_addr    = data_addr;
      sram_wdata   = data_wdata;
      state_d      = DATA_RESP;
      if (inst_req && (starve_cnt_q != STARVE_W'(STARVE_LIMIT))) begin
        starve_cnt_d = starve_cnt_q + STARVE_W'(1);
      end
    end else if (grant_inst) begin
      inst_addr_ok = 1'b1;
      sram_en      = 1'b1;
      sram_addr    = inst_addr;
      state_d      = INST_RESP;
      starve_cnt_d = '0;
    end
  end

  // Response side: one cycle after a grant, route the SRAM read data to its owner.
  // A reset in the response cycle drops the pending data_ok.
  always_comb begin
    inst_data_ok = 1'b0;
    inst_rdata   = 32'h0;
    data_data_ok = 1'b0;
    data_rdata   = 32'h0;
    if (!reset) begin
      case (state_q)
        INST_RESP: begin
          inst_data_ok = 1'b1;
          inst_rdata   = sram_rdata;
        end
        DATA_RESP: begin
          data_data_ok = 1'b1;
          data_rdata   = sram_rdata;
        end
        default: ;
      endcase
    end
  end

  // State and starvation counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_inst_q, perf_inst_d;
  logic [31:0] perf_data_q, perf_data_d;
  logic [31:0] perf_conf_q, perf_conf_d;

  // Wrapping event counters for grants and contested cycles.
  always_comb begin
    perf_inst_d = perf_inst_q;
    perf_data_d = perf_data_q;
    perf_conf_d = perf_conf_q;
    if (grant_inst)           perf_inst_d = perf_inst_q + 32'd1;
    if (grant_data)           perf_data_d = perf_data_q + 32'd1;
    if (inst_req && data_req) perf_conf_d = perf_conf_q + 32'd1;
  end

  // Performance counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_inst_q <= 32'h0;
      perf_data_q <= 32'h0;
      perf_conf_q <= 32'h0;
    end else begin
      perf_inst_q <= perf_inst_d;
      perf_data_q <= perf_data_d;
      perf_conf_q <= perf_conf_d;
    end
  end

  assign perf_inst_grants = perf_inst_q;
  assign perf_data_grants = perf_data_q;
  assign perf_conflicts   = perf_conf_q;
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed self-checking bench for sram_port_arbiter with a behavioural
// zero-initialised SRAM (1-cycle read latency, byte write enables).
module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic [3:0]  data_we;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        sram_en;
  logic [3:0]  sram_we;
  logic [31:0] sram_addr, sram_wdata;
  logic [31:0] sram_rdata;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_inst_grants, perf_data_grants, perf_conflicts;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mem [0:255];

  sram_port_arbiter #(.STARVE_LIMIT(4), .STARVE_W(3)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
`ifdef ARB_PERF_CNT_EN
    .perf_inst_grants(perf_inst_grants), .perf_data_grants(perf_data_grants),
    .perf_conflicts(perf_conflicts),
`endif
    .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM: word index from addr[9:2], read data registered one cycle after enable.
  always @(posedge clk) begin
    if (sram_en) begin
      for (int b = 0; b < 4; b++) begin
        if (sram_we[b]) mem[sram_addr[9:2]][b*8 +: 8] <= sram_wdata[b*8 +: 8];
      end
      sram_rdata <= mem[sram_addr[9:2]];
    end
  end

  task automatic idle_inputs();
    inst_req = 1'b0; inst_addr = 32'h0;
    data_req = 1'b0; data_we = 4'b0; data_addr = 32'h0; data_wdata = 32'h0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; inst_req = 1'b1; inst_addr = 32'h1c000000;
    data_req = 1'b1; data_addr = 32'h40;
    #1;
    n_cmp++; if (inst_addr_ok !== 1'b0) begin n_err++; $display("FAIL rst_inst_addr_ok: got %b want 0", inst_addr_ok); end
    n_cmp++; if (data_addr_ok !== 1'b0) begin n_err++; $display("FAIL rst_data_addr_ok: got %b want 0", data_addr_ok); end
    n_cmp++; if (sram_en !== 1'b0) begin n_err++; $display("FAIL rst_sram_en: got %b want 0", sram_en); end
    @(negedge clk);
    reset = 1'b0; idle_inputs();
    #1;
    n_cmp++; if (inst_data_ok !== 1'b0) begin n_err++; $display("FAIL rst_inst_data_ok: got %b want 0", inst_data_ok); end
    n_cmp++; if (data_data_ok !== 1'b0) begin n_err++; $display("FAIL rst_data_data_ok: got %b want 0", data_data_ok); end
    n_cmp++; if (sram_we !== 4'b0) begin n_err++; $display("FAIL rst_sram_we: got %b want 0000", sram_we); end
`ifdef ARB_PERF_CNT_EN
    n_cmp++; if (perf_conflicts !== 32'd0) begin n_err++; $display("FAIL rst_perf_conf: got %0d want 0", perf_conflicts); end
`endif
  endtask

  task automatic test_single_fetch();
    @(negedge clk);
    inst_req = 1'b1; inst_addr = 32'h1c000000;
    #1;
    n_cmp++; if (inst_addr_ok !== 1'b1) begin n_err++; $display("FAIL f1_addr_ok: got %b want 1", inst_addr_ok); end
    n_cmp++; if (sram_addr !== 32'h1c000000) begin n_err++; $display("FAIL f1_sram_addr: got %h want 1c000000", sram_addr); end
    n_cmp++; if (inst_data_ok !== 1'b0) begin n_err++; $display("FAIL f1_early_data_ok: got %b want 0", inst_data_ok); end
    @(negedge clk);
    idle_inputs();
    #1;
    n_cmp++; if (inst_data_ok !== 1'b1) begin n_err++; $display("FAIL f1_data_ok: got %b want 1", inst_data_ok); end
    n_cmp++; if (inst_rdata !== 32'h02800000) begin n_err++; $display("FAIL f1_rdata: got %h want 02800000", inst_rdata); end
    @(negedge clk);
    #1;
    n_cmp++; if (inst_data_ok !== 1'b0) begin n_err++; $display("FAIL f1_data_ok_pulse: got %b want 0", inst_data_ok); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [0:2];
    logic [31:0] exp_rd [0:2];
    addrs[0] = 32'h1c000000; addrs[1] = 32'h1c000004; addrs[2] = 32'h1c000008;
    exp_rd[0] = 32'h02800000; exp_rd[1] = 32'h11112222; exp_rd[2] = 32'h33334444;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k < 3) begin inst_req = 1'b1; inst_addr = addrs[k]; end
      else idle_inputs();
      #1;
      if (k < 3) begin
        n_cmp++; if (inst_addr_ok !== 1'b1) begin n_err++; $display("FAIL b2b_addr_ok[%0d]: got %b want 1", k, inst_addr_ok); end
      end
      if (k > 0) begin
        n_cmp++; if (inst_data_ok !== 1'b1) begin n_err++; $display("FAIL b2b_data_ok[%0d]: got %b want 1", k, inst_data_ok); end
        n_cmp++; if (inst_rdata !== exp_rd[k-1]) begin n_err++; $display("FAIL b2b_rdata[%0d]: got %h want %h", k, inst_rdata, exp_rd[k-1]); end
      end
    end
  endtask

  task automatic test_contention();
    @(negedge clk);
    inst_req = 1'b1; inst_addr = 32'h1c000000;
    data_req = 1'b1; data_we = 4'b0; data_addr = 32'h10;
    #1;
    n_cmp++; if (data_addr_ok !== 1'b1) begin n_err++; $display("FAIL c_data_addr_ok: got %b want 1", data_addr_ok); end
    n_cmp++; if (inst_addr_ok !== 1'b0) begin n_err++; $display("FAIL c_inst_addr_ok_T: got %b want 0", inst_addr_ok); end
    @(negedge clk);
    data_req = 1'b0;
    #1;
    n_cmp++; if (inst_addr_ok !== 1'b1) begin n_err++; $display("FAIL c_inst_addr_ok_T1: got %b want 1", inst_addr_ok); end
    n_cmp++; if (data_data_ok !== 1'b1) begin n_err++; $display("FAIL c_data_data_ok: got %b want 1", data_data_ok); end
    @(negedge clk);
    idle_inputs();
    #1;
    n_cmp++; if (inst_data_ok !== 1'b1) begin n_err++; $display("FAIL c_inst_data_ok: got %b want 1", inst_data_ok); end
    n_cmp++; if (data_data_ok !== 1'b0) begin n_err++; $display("FAIL c_data_data_ok_T2: got %b want 0", data_data_ok); end
  endtask

  task automatic test_store_load();
    @(negedge clk);
    data_req = 1'b1; data_we = 4'b0011; data_addr = 32'h10; data_wdata = 32'hdeadbeef;
    #1;
    n_cmp++; if (data_addr_ok !== 1'b1) begin n_err++; $display("FAIL st_addr_ok: got %b want 1", data_addr_ok); end
    n_cmp++; if (sram_we !== 4'b0011) begin n_err++; $display("FAIL st_sram_we: got %b want 0011", sram_we); end
    n_cmp++; if (sram_wdata !== 32'hdeadbeef) begin n_err++; $display("FAIL st_sram_wdata: got %h want deadbeef", sram_wdata); end
    @(negedge clk);
    data_we = 4'b0; data_wdata = 32'h0;
    #1;
    n_cmp++; if (data_data_ok !== 1'b1) begin n_err++; $display("FAIL st_data_ok: got %b want 1", data_data_ok); end
    n_cmp++; if (data_addr_ok !== 1'b1) begin n_err++; $display("FAIL ld_addr_ok: got %b want 1", data_addr_ok); end
    n_cmp++; if (sram_we !== 4'b0) begin n_err++; $display("FAIL ld_sram_we: got %b want 0000", sram_we); end
    @(negedge clk);
    idle_inputs();
    #1;
    n_cmp++; if (data_data_ok !== 1'b1) begin n_err++; $display("FAIL ld_data_ok: got %b want 1", data_data_ok); end
    n_cmp++; if (data_rdata !== 32'h0000beef) begin n_err++; $display("FAIL ld_rdata: got %h want 0000beef", data_rdata); end
  endtask

  task automatic test_starve();
    logic exp_inst;
    logic exp_prev_inst;
    @(negedge clk);
    reset = 1'b1; idle_inputs();
    @(negedge clk);
    reset = 1'b0;
    inst_req = 1'b1; inst_addr = 32'h1c000000;
    data_req = 1'b1; data_we = 4'b0; data_addr = 32'h20;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      exp_inst = ((k % 5) == 4);
      n_cmp++; if (inst_addr_ok !== exp_inst) begin n_err++; $display("FAIL sv_inst_addr_ok[%0d]: got %b want %b", k, inst_addr_ok, exp_inst); end
      n_cmp++; if (data_addr_ok !== !exp_inst) begin n_err++; $display("FAIL sv_data_addr_ok[%0d]: got %b want %b", k, data_addr_ok, !exp_inst); end
      if (k > 0) begin
        exp_prev_inst = (((k - 1) % 5) == 4);
        n_cmp++; if (inst_data_ok !== exp_prev_inst) begin n_err++; $display("FAIL sv_inst_data_ok[%0d]: got %b want %b", k, inst_data_ok, exp_prev_inst); end
      end
    end
    @(negedge clk);
    idle_inputs();
    #1;
    n_cmp++; if (inst_data_ok !== 1'b1) begin n_err++; $display("FAIL sv_last_inst_data_ok: got %b want 1", inst_data_ok); end
`ifdef ARB_PERF_CNT_EN
    n_cmp++; if (perf_data_grants !== 32'd8) begin n_err++; $display("FAIL perf_data: got %0d want 8", perf_data_grants); end
    n_cmp++; if (perf_inst_grants !== 32'd2) begin n_err++; $display("FAIL perf_inst: got %0d want 2", perf_inst_grants); end
    n_cmp++; if (perf_conflicts !== 32'd10) begin n_err++; $display("FAIL perf_conf: got %0d want 10", perf_conflicts); end
`endif
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    inst_req = 1'b1; inst_addr = 32'h1c000004;
    #1;
    n_cmp++; if (inst_addr_ok !== 1'b1) begin n_err++; $display("FAIL rm_addr_ok: got %b want 1", inst_addr_ok); end
    @(negedge clk);
    reset = 1'b1; idle_inputs();
    #1;
    n_cmp++; if (inst_data_ok !== 1'b0) begin n_err++; $display("FAIL rm_dropped_data_ok: got %b want 0", inst_data_ok); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++; if (inst_data_ok !== 1'b0) begin n_err++; $display("FAIL rm_inst_data_ok_T2: got %b want 0", inst_data_ok); end
    n_cmp++; if (data_data_ok !== 1'b0) begin n_err++; $display("FAIL rm_data_data_ok_T2: got %b want 0", data_data_ok); end
    n_cmp++; if (sram_en !== 1'b0) begin n_err++; $display("FAIL rm_sram_en_T2: got %b want 0", sram_en); end
    n_cmp++; if (inst_addr_ok !== 1'b0) begin n_err++; $display("FAIL rm_inst_addr_ok_T2: got %b want 0", inst_addr_ok); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0] = 32'h02800000;
    mem[1] = 32'h11112222;
    mem[2] = 32'h33334444;
    sram_rdata = 32'h0;
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b0;

    test_reset();
    test_single_fetch();
    test_back_to_back();
    test_contention();
    test_store_load();
    test_starve();
    test_reset_mid();

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
